// File: rtl/break_count_collector_if.sv
// Batch, cluster and result signals of the break-count collector.
// The slave modport is the collector; the master modport is its environment.
interface break_count_collector_if #(
  parameter int unsigned CLUSTER_SIZE = 20,
  parameter int unsigned LIT_W        = 40,
  parameter int unsigned COUNT_W      = 16
);
  logic                    batch_valid_i;
  logic                    batch_ready_o;
  logic [LIT_W-1:0]        batch_val_i;
  logic [LIT_W-1:0]        batch_neg_i;
  logic [CLUSTER_SIZE-1:0] batch_mask_i;
  logic                    batch_last_i;
  logic [LIT_W-1:0]        var_val_mo;
  logic [LIT_W-1:0]        var_neg_mo;
  logic [CLUSTER_SIZE-1:0] break_mi;
  logic                    count_valid_o;
  logic                    count_ready_i;
  logic [COUNT_W-1:0]      break_count_o;
  logic                    count_sat_o;

  modport slave (
    input  batch_valid_i, batch_val_i, batch_neg_i, batch_mask_i, batch_last_i,
    input  break_mi, count_ready_i,
    output batch_ready_o, var_val_mo, var_neg_mo,
    output count_valid_o, break_count_o, count_sat_o
  );

  modport master (
    output batch_valid_i, batch_val_i, batch_neg_i, batch_mask_i, batch_last_i,
    output break_mi, count_ready_i,
    input  batch_ready_o, var_val_mo, var_neg_mo,
    input  count_valid_o, break_count_o, count_sat_o
  );
endinterface

// File: rtl/break_count_collector.sv
// Feeds clause batches to an evaluator cluster, waits out its pipeline and
// accumulates the masked break bits into one saturating total per candidate.
module break_count_collector #(
  parameter int unsigned CLUSTER_SIZE = 20,
  parameter int unsigned NSAT         = 3,
  parameter int unsigned REDUCE       = 1,
  parameter int unsigned EVAL_LATENCY = 2,
  parameter int unsigned COUNT_W      = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  break_count_collector_if.slave bus
);
  localparam int unsigned LIT_W = (NSAT - REDUCE) * CLUSTER_SIZE;
  localparam int unsigned POP_W = $clog2(CLUSTER_SIZE + 1);
  localparam int unsigned CNT_W = $clog2(EVAL_LATENCY + 1);
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, WAIT, ACCUM, DONE} state_e;

  state_e                  state_q, state_d;
  logic [LIT_W-1:0]        var_val_q, var_val_d;
  logic [LIT_W-1:0]        var_neg_q, var_neg_d;
  logic [CLUSTER_SIZE-1:0] mask_q, mask_d;
  logic                    last_q, last_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [COUNT_W-1:0]      acc_q, acc_d;
  logic                    sat_q, sat_d;
  logic                    ready_q, ready_d;
  logic                    count_valid_q, count_valid_d;
  logic [COUNT_W-1:0]      break_count_q, break_count_d;

  logic [POP_W-1:0]        pop_c;
  logic [COUNT_W:0]        sum_c;

  // Masked popcount of the cluster's break bits plus the running total.
  always_comb begin
    pop_c = '0;
    for (int i = 0; i < int'(CLUSTER_SIZE); i++) begin
      pop_c = pop_c + POP_W'(bus.break_mi[i] & mask_q[i]);
    end
    sum_c = (COUNT_W+1)'(acc_q) + (COUNT_W+1)'(pop_c);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      var_val_q     <= '0;
      var_neg_q     <= '0;
      mask_q        <= '0;
      last_q        <= 1'b0;
      cnt_q         <= '0;
      acc_q         <= '0;
      sat_q         <= 1'b0;
      ready_q       <= 1'b0;
      count_valid_q <= 1'b0;
      break_count_q <= '0;
    end else begin
      state_q       <= state_d;
      var_val_q     <= var_val_d;
      var_neg_q     <= var_neg_d;
      mask_q        <= mask_d;
      last_q        <= last_d;
      cnt_q         <= cnt_d;
      acc_q         <= acc_d;
      sat_q         <= sat_d;
      ready_q       <= ready_d;
      count_valid_q <= count_valid_d;
      break_count_q <= break_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    var_val_d     = var_val_q;
    var_neg_d     = var_neg_q;
    mask_d        = mask_q;
    last_d        = last_q;
    cnt_d         = cnt_q;
    acc_d         = acc_q;
    sat_d         = sat_q;
    count_valid_d = count_valid_q;
    break_count_d = break_count_q;

    unique case (state_q)
      IDLE: begin
        if (bus.batch_valid_i && ready_q) begin
          var_val_d = bus.batch_val_i;
          var_neg_d = bus.batch_neg_i;
          mask_d    = bus.batch_mask_i;
          last_d    = bus.batch_last_i;
          cnt_d     = CNT_W'(EVAL_LATENCY);
          state_d   = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ACCUM;
      end
      ACCUM: begin
        // Clamp once the total would overflow; the flag stays up until handshake.
        if (sum_c > {1'b0, COUNT_MAX}) begin
          acc_d = COUNT_MAX;
          sat_d = 1'b1;
        end else begin
          acc_d = sum_c[COUNT_W-1:0];
        end
        if (last_q) begin
          break_count_d = acc_d;
          count_valid_d = 1'b1;
          state_d       = DONE;
        end else begin
          state_d = IDLE;
        end
      end
      DONE: begin
        if (count_valid_q && bus.count_ready_i) begin
          count_valid_d = 1'b0;
          acc_d         = '0;
          sat_d         = 1'b0;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
  end

  assign bus.batch_ready_o = ready_q;
  assign bus.var_val_mo    = var_val_q;
  assign bus.var_neg_mo    = var_neg_q;
  assign bus.count_valid_o = count_valid_q;
  assign bus.break_count_o = break_count_q;
  assign bus.count_sat_o   = sat_q;
endmodule

// File: tb/tb_break_count_collector.sv
// Drives a 16-bit and a 5-bit accumulator instance with identical batches and
// checks both totals against a clause-counting reference model.
module tb_break_count_collector;
  localparam int unsigned CS    = 20;
  localparam int unsigned LIT_W = 40;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             bvalid, last_r, cready;
  logic [LIT_W-1:0] val_r, neg_r;
  logic [CS-1:0]    mask_r;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_sum  = 0;

  break_count_collector_if #(.CLUSTER_SIZE(CS), .LIT_W(LIT_W), .COUNT_W(16)) if16 ();
  break_count_collector_if #(.CLUSTER_SIZE(CS), .LIT_W(LIT_W), .COUNT_W(5))  if5  ();

  break_count_collector #(.COUNT_W(16)) u_dut16 (.clk_i(clk), .rst_ni(rst_n), .bus(if16));
  break_count_collector #(.COUNT_W(5))  u_dut5  (.clk_i(clk), .rst_ni(rst_n), .bus(if5));

  always #5 clk = ~clk;

  assign if16.batch_valid_i = bvalid;
  assign if16.batch_val_i   = val_r;
  assign if16.batch_neg_i   = neg_r;
  assign if16.batch_mask_i  = mask_r;
  assign if16.batch_last_i  = last_r;
  assign if16.count_ready_i = cready;
  assign if5.batch_valid_i  = bvalid;
  assign if5.batch_val_i    = val_r;
  assign if5.batch_neg_i    = neg_r;
  assign if5.batch_mask_i   = mask_r;
  assign if5.batch_last_i   = last_r;
  assign if5.count_ready_i  = cready;

  // Stand-in cluster: a literal holds when val=1 and neg=0; a clause breaks
  // when neither of its remaining literals holds.
  function automatic logic [CS-1:0] cluster_break(input logic [LIT_W-1:0] v, input logic [LIT_W-1:0] n);
    logic [CS-1:0] b;
    for (int c = 0; c < int'(CS); c++)
      b[c] = !((v[2*c] && !n[2*c]) || (v[2*c+1] && !n[2*c+1]));
    return b;
  endfunction

  logic [CS-1:0] c16_s1, c16_s2, c5_s1, c5_s2;
  always @(posedge clk) begin
    c16_s1 <= cluster_break(if16.var_val_mo, if16.var_neg_mo);
    c16_s2 <= c16_s1;
    c5_s1  <= cluster_break(if5.var_val_mo, if5.var_neg_mo);
    c5_s2  <= c5_s1;
  end
  assign if16.break_mi = c16_s2;
  assign if5.break_mi  = c5_s2;

  // Reference: number of real clauses in which no literal is satisfied.
  function automatic int model_breaks(input logic [LIT_W-1:0] v, input logic [LIT_W-1:0] n,
                                      input logic [CS-1:0] m);
    int cnt = 0;
    for (int c = 0; c < int'(CS); c++) begin
      int sat_lits = 0;
      for (int l = 0; l < 2; l++)
        if (v[2*c+l] == 1'b1 && n[2*c+l] == 1'b0) sat_lits++;
      if (m[c] && sat_lits == 0) cnt++;
    end
    return cnt;
  endfunction

  function automatic logic [63:0] clampw(input int s, input int w);
    int mx = (1 << w) - 1;
    return (s > mx) ? 64'(mx) : 64'(s);
  endfunction

  function automatic logic [63:0] satw(input int s, input int w);
    return (s > (1 << w) - 1) ? 64'd1 : 64'd0;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_result(input string tag);
    check({tag, "_valid16"}, 64'(if16.count_valid_o), 64'd1);
    check({tag, "_valid5"},  64'(if5.count_valid_o),  64'd1);
    check({tag, "_count16"}, 64'(if16.break_count_o), clampw(exp_sum, 16));
    check({tag, "_count5"},  64'(if5.break_count_o),  clampw(exp_sum, 5));
    check({tag, "_sat16"},   64'(if16.count_sat_o),   satw(exp_sum, 16));
    check({tag, "_sat5"},    64'(if5.count_sat_o),    satw(exp_sum, 5));
  endtask

  // Offer one batch, confirm the 3-cycle busy window, then check the outcome.
  task automatic do_batch(input logic [LIT_W-1:0] v, input logic [LIT_W-1:0] n,
                          input logic [CS-1:0] m, input logic l, output int waits);
    val_r = v; neg_r = n; mask_r = m; last_r = l; bvalid = 1'b1;
    waits = 0;
    while (!if16.batch_ready_o && waits < 20) begin
      @(posedge clk); #1;
      waits++;
    end
    check("accept_ready", 64'(if16.batch_ready_o & if5.batch_ready_o), 64'd1);
    @(posedge clk); #1;
    bvalid = 1'b0;
    exp_sum += model_breaks(v, n, m);
    check("var_val", 64'(if16.var_val_mo), 64'(v));
    check("var_neg", 64'(if5.var_neg_mo), 64'(n));
    for (int k = 0; k < 3; k++) begin
      check("busy_ready", 64'(if16.batch_ready_o | if5.batch_ready_o), 64'd0);
      check("early_valid", 64'(if16.count_valid_o | if5.count_valid_o), 64'd0);
      @(posedge clk); #1;
    end
    if (!l) begin
      check("ready_back", 64'(if16.batch_ready_o & if5.batch_ready_o), 64'd1);
      check("no_valid", 64'(if16.count_valid_o | if5.count_valid_o), 64'd0);
    end else begin
      check_result("result");
    end
  endtask

  // Hold the result under backpressure, then complete the handshake.
  task automatic finish_result(input int hold, input logic offer);
    cready = 1'b0;
    bvalid = offer;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check_result("hold");
      check("hold_ready", 64'(if16.batch_ready_o | if5.batch_ready_o), 64'd0);
    end
    cready = 1'b1;
    @(posedge clk); #1;
    cready = 1'b0;
    check("hs_valid", 64'(if16.count_valid_o | if5.count_valid_o), 64'd0);
    check("hs_sat", 64'(if16.count_sat_o | if5.count_sat_o), 64'd0);
    check("hs_ready", 64'(if16.batch_ready_o & if5.batch_ready_o), 64'd1);
    exp_sum = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 64'(if16.batch_ready_o | if5.batch_ready_o), 64'd0);
    check({tag, "_val"},   64'(if16.var_val_mo | if5.var_val_mo), 64'd0);
    check({tag, "_neg"},   64'(if16.var_neg_mo | if5.var_neg_mo), 64'd0);
    check({tag, "_valid"}, 64'(if16.count_valid_o | if5.count_valid_o), 64'd0);
    check({tag, "_count"}, 64'(if16.break_count_o) | 64'(if5.break_count_o), 64'd0);
    check({tag, "_sat"},   64'(if16.count_sat_o | if5.count_sat_o), 64'd0);
  endtask

  localparam logic [LIT_W-1:0] ONES = '1;
  localparam logic [CS-1:0]    FULL = '1;

  initial begin
    int w;
    logic [63:0] r;
    logic [LIT_W-1:0] rv, rn;
    logic [CS-1:0] rm;
    int nb;

    bvalid = 1'b0; last_r = 1'b0; cready = 1'b0;
    val_r = '0; neg_r = '0; mask_r = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #3 check_reset_outputs("por");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_ready", 64'(if16.batch_ready_o & if5.batch_ready_o), 64'd1);

    // All clauses broken, then none broken.
    do_batch('0, ONES, FULL, 1'b1, w);
    finish_result(0, 1'b0);
    do_batch(ONES, '0, FULL, 1'b1, w);
    finish_result(0, 1'b0);

    // Multi-batch with padded and all-padding batches: 20 + 8 + 0.
    do_batch('0, ONES, FULL, 1'b0, w);
    do_batch('0, ONES, 20'h000FF, 1'b0, w);
    do_batch('0, ONES, 20'h00000, 1'b1, w);
    check("multi_total", 64'(if16.break_count_o), 64'd28);
    finish_result(1, 1'b0);

    // 40 breaks saturate the 5-bit instance; next candidate starts clean.
    do_batch('0, ONES, FULL, 1'b0, w);
    do_batch('0, ONES, FULL, 1'b1, w);
    check("sat5_count", 64'(if5.break_count_o), 64'd31);
    check("sat5_flag", 64'(if5.count_sat_o), 64'd1);
    finish_result(0, 1'b0);
    do_batch(ONES, '0, FULL, 1'b1, w);
    finish_result(0, 1'b0);

    // Backpressure with the next batch already offered.
    do_batch('0, ONES, FULL, 1'b1, w);
    val_r = ONES; neg_r = '0; mask_r = FULL; last_r = 1'b1;
    finish_result(5, 1'b1);
    do_batch(ONES, '0, FULL, 1'b1, w);
    check("bp_accept_wait", 64'(w), 64'd0);
    finish_result(0, 1'b0);

    // Reset while the second batch of a candidate is in WAIT.
    do_batch('0, ONES, FULL, 1'b0, w);
    val_r = '0; neg_r = ONES; mask_r = FULL; last_r = 1'b0; bvalid = 1'b1;
    @(posedge clk); #1;
    bvalid = 1'b0;
    rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    @(posedge clk);
    #3 rst_n = 1'b1;
    exp_sum = 0;
    @(posedge clk); #1;
    check("post_rst_ready", 64'(if16.batch_ready_o), 64'd1);
    do_batch('0, ONES, FULL, 1'b1, w);
    check("post_rst_total", 64'(if16.break_count_o), 64'd20);
    finish_result(0, 1'b0);

    // Random candidates.
    for (int cand = 0; cand < 30; cand++) begin
      nb = int'($urandom_range(1, 5));
      for (int b = 0; b < nb; b++) begin
        r  = {$urandom, $urandom};
        rv = r[LIT_W-1:0];
        r  = {$urandom, $urandom};
        rn = r[LIT_W-1:0];
        r  = {$urandom, $urandom};
        rm = ($urandom_range(0, 7) == 0) ? '0 : r[CS-1:0];
        do_batch(rv, rn, rm, (b == nb - 1), w);
      end
      finish_result(int'($urandom_range(0, 3)), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
